d_cache_wb_nway: RTL and testbench



---
 rtl/d_cache_wb_nway.sv | 188 ++++++++++++++++++
 tb/tb_d_cache_wb_nway.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_wb_nway.sv
// N-way set-associative write-back, write-allocate data cache.
// Sram-like handshake toward the core and toward memory; line refill and
// dirty write-back are sequences of single-word memory transfers.
module d_cache_wb_nway #(
    parameter int INDEX_WIDTH       = 7,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WAY_WIDTH         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << WORD_OFFSET_WIDTH;
    localparam int WAYS       = 1 << WAY_WIDTH;
    localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - WORD_OFFSET_WIDTH - 2;
    // zero-width parameters still get a 1-bit signal that stays at 0
    localparam int KW = (WORD_OFFSET_WIDTH > 0) ? WORD_OFFSET_WIDTH : 1;
    localparam int WW = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

    typedef enum logic [1:0] {IDLE, WB, RF} state_t;

    // storage
    logic [31:0]          data_mem [WAYS][SETS][LINE_WORDS];
    logic [TAG_WIDTH-1:0] tag_mem  [WAYS][SETS];
    logic [SETS-1:0]      valid    [WAYS];
    logic [SETS-1:0]      dirty    [WAYS];
    logic [WW-1:0]        rr       [SETS];

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   cpu_tag, tag_save, vtag_q, line_tag;
    logic [INDEX_WIDTH-1:0] cpu_index, index_save;
    logic [KW-1:0]          cpu_word, k_q;
    logic [WAYS-1:0]        way_hit;
    logic [WW-1:0]          hit_way, vict_way, vway_q;
    logic                   hit, vict_rr, vrr_q, wait_q, xfer_ok, last_word, cpu_ok;
    logic [3:0]             byte_mask;

    assign cpu_tag   = cpu_data_addr[31 -: TAG_WIDTH];
    assign cpu_index = cpu_data_addr[WORD_OFFSET_WIDTH+2 +: INDEX_WIDTH];

    if (WORD_OFFSET_WIDTH > 0) begin : g_word
        assign cpu_word = cpu_data_addr[WORD_OFFSET_WIDTH+1:2];
    end else begin : g_noword
        assign cpu_word = 1'b0;
    end

    // per-way tag compare
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_hit[w] = valid[w][cpu_index] && (tag_mem[w][cpu_index] == cpu_tag);
    end
    assign hit = |way_hit;

    // encode the (single) hitting way
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_way = WW'(w);
    end

    // victim: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        vict_way = rr[cpu_index];
        vict_rr  = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w][cpu_index]) begin
                vict_way = WW'(w);
                vict_rr  = 1'b0;
            end
    end

    // store byte lanes from size and low address bits
    always_comb begin
        byte_mask = 4'b0000;
        case (cpu_data_size)
            2'b00:   byte_mask = 4'b0001 << cpu_data_addr[1:0];
            2'b01:   byte_mask = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    end

    // one memory transfer outstanding: req until addr_ok, then wait for data_ok
    assign cache_data_req = (state_q != IDLE) && !wait_q;
    assign xfer_ok   = cache_data_data_ok && (wait_q || (cache_data_req && cache_data_addr_ok));
    assign last_word = (k_q == KW'(LINE_WORDS - 1));

    // next state and CPU handshake
    always_comb begin
        state_d = state_q;
        cpu_ok  = 1'b0;
        case (state_q)
            IDLE: if (cpu_data_req) begin
                if (hit) cpu_ok = 1'b1;
                else     state_d = (valid[vict_way][cpu_index] && dirty[vict_way][cpu_index]) ? WB : RF;
            end
            WB: if (xfer_ok && last_word) state_d = RF;
            RF: if (xfer_ok && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cpu_data_addr_ok = cpu_ok;
    assign cpu_data_data_ok = cpu_ok;
    assign cpu_data_rdata   = data_mem[hit_way][cpu_index][cpu_word];

    // memory-side address and data
    assign line_tag         = (state_q == WB) ? vtag_q : tag_save;
    assign cache_data_addr  = {line_tag, index_save, {(WORD_OFFSET_WIDTH+2){1'b0}}} | (32'(k_q) << 2);
    assign cache_data_wr    = (state_q == WB);
    assign cache_data_size  = 2'b10;
    assign cache_data_wdata = data_mem[vway_q][index_save][k_q];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // word counter and outstanding-transfer flag
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            wait_q <= 1'b0;
            k_q    <= '0;
        end else if (xfer_ok) begin
            wait_q <= 1'b0;
            k_q    <= last_word ? '0 : k_q + KW'(1);
        end else if (cache_data_req && cache_data_addr_ok) begin
            wait_q <= 1'b1;
        end
    end

    // capture the missing line and its victim
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cpu_data_req && !hit) begin
            tag_save   <= cpu_tag;
            index_save <= cpu_index;
            vway_q     <= vict_way;
            vrr_q      <= vict_rr;
            vtag_q     <= tag_mem[vict_way][cpu_index];
        end
    end

    // valid / dirty / round-robin bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            if (cpu_ok && cpu_data_wr) dirty[hit_way][cpu_index] <= 1'b1;
            if (state_q == RF && xfer_ok && last_word) begin
                valid[vway_q][index_save] <= 1'b1;
                dirty[vway_q][index_save] <= 1'b0;
                if (WAY_WIDTH > 0 && vrr_q) rr[index_save] <= rr[index_save] + WW'(1);
            end
        end
    end

    // line data and tags: store merge on hit, refill words as they arrive
    always_ff @(posedge clk) begin
        if (cpu_ok && cpu_data_wr)
            for (int b = 0; b < 4; b++)
                if (byte_mask[b])
                    data_mem[hit_way][cpu_index][cpu_word][8*b +: 8] <= cpu_data_wdata[8*b +: 8];
        if (state_q == RF && xfer_ok) begin
            data_mem[vway_q][index_save][k_q] <= cache_data_rdata;
            if (last_word) tag_mem[vway_q][index_save] <= tag_save;
        end
    end
endmodule

// File: tb/tb_d_cache_wb_nway.sv
// Directed bench for d_cache_wb_nway: behavioural memory slave with
// programmable handshake delays, transaction log, and hand-computed checks.
module tb_d_cache_wb_nway;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_data_req, cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
    logic        cache_data_addr_ok, cache_data_data_ok;

    int n_assert = 0;
    int n_fail   = 0;

    d_cache_wb_nway dut (
        .clk(clk), .rst(rst),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
        .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
        .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
        .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
        .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
        .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
        .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
        .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
    );

    always #5 clk = ~clk;

    // ---------------- memory slave ----------------
    int          adly = 0, ddly = 0;
    logic        s_phase = 1'b0;
    int          s_cnt = 0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic        s_wr = 1'b0;
    logic [31:0] mem [4096];
    logic        mem_ready = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    int          viol = 0;
    logic [31:0] log_addr  [512];
    logic [31:0] log_wdata [512];
    logic        log_wr    [512];
    int          log_n = 0;

    assign cache_data_addr_ok = !s_phase && cache_data_req && (s_cnt >= adly);
    assign cache_data_data_ok = s_phase && (s_cnt >= ddly);
    assign cache_data_rdata   = s_phase ? mem[s_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            s_phase   <= 1'b0;
            s_cnt     <= 0;
            prev_pend <= 1'b0;
            if (!mem_ready) begin
                for (int i = 0; i < 4096; i++) mem[i] <= 32'hA000_0000 | (32'(i) << 2);
                mem[1024] <= 32'h11; mem[1025] <= 32'h22;
                mem[1026] <= 32'h33; mem[1027] <= 32'h44;
                mem_ready <= 1'b1;
            end
        end else begin
            prev_pend <= cache_data_req && !cache_data_addr_ok;
            prev_addr <= cache_data_addr;
            if ((prev_pend && !cache_data_req) || (s_phase && cache_data_req) ||
                (prev_pend && cache_data_req && cache_data_addr != prev_addr))
                viol <= viol + 1;
            if (!s_phase) begin
                if (cache_data_req) begin
                    if (s_cnt >= adly) begin
                        s_phase <= 1'b1;
                        s_cnt   <= 0;
                        s_addr  <= cache_data_addr;
                        s_wr    <= cache_data_wr;
                        s_wdata <= cache_data_wdata;
                        log_addr[log_n]  <= cache_data_addr;
                        log_wr[log_n]    <= cache_data_wr;
                        log_wdata[log_n] <= cache_data_wdata;
                        log_n <= log_n + 1;
                    end else s_cnt <= s_cnt + 1;
                end
            end else if (s_cnt >= ddly) begin
                if (s_wr) mem[s_addr[13:2]] <= s_wdata;
                s_phase <= 1'b0;
                s_cnt   <= 0;
            end else s_cnt <= s_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one CPU request, hold it until data_ok; cyc = cycles before completion
    task automatic cpu_op(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = size;
        cpu_data_addr = addr; cpu_data_wdata = wdata;
        cyc = 0;
        rd  = 'x;
        while (1) begin
            #1;
            if (cpu_data_data_ok) begin
                rd = cpu_data_rdata;
                check("addr_ok_with_data_ok", 32'(cpu_data_addr_ok), 32'd1);
                break;
            end
            if (cyc >= 500) begin
                check("cpu_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        cpu_data_req = 1'b0; cpu_data_wr = 1'b0;
    endtask

    // check n consecutive logged transfers starting at entry first
    task automatic check_log(input string tag, input int first, input int n,
                             input logic wr, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, log_addr[first+i], base + 32'(i*4));
            check({tag, "_wr"}, 32'(log_wr[first+i]), 32'(wr));
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd;
    int          cyc, mark;
    logic [31:0] wb_exp [4];

    initial begin
        rst = 1'b1; cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'b10;
        cpu_data_addr = '0; cpu_data_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(cache_data_req), 32'd0);
        check("rst_mem_wr", 32'(cache_data_wr), 32'd0);
        check("rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
        check("rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
        check("mem_size", 32'(cache_data_size), 32'd2);
        rst = 1'b0;

        // cold load: four refill reads, then the re-hit
        mark = log_n;
        cpu_op(1'b0, 2'b10, 32'h1004, '0, rd, cyc);
        check("cold_rdata", rd, 32'h22);
        check("cold_cycles", 32'(cyc), 32'd9);
        check("cold_ntx", 32'(log_n - mark), 32'd4);
        check_log("cold", mark, 4, 1'b0, 32'h1000);

        mark = log_n;
        cpu_op(1'b0, 2'b10, 32'h1004, '0, rd, cyc);
        check("rehit_rdata", rd, 32'h22);
        check("rehit_cycles", 32'(cyc), 32'd0);
        check("rehit_ntx", 32'(log_n - mark), 32'd0);

        // byte store hit, then readback
        mark = log_n;
        cpu_op(1'b1, 2'b00, 32'h1005, 32'h0000_AB00, rd, cyc);
        check("sb_cycles", 32'(cyc), 32'd0);
        cpu_op(1'b0, 2'b10, 32'h1004, '0, rd, cyc);
        check("sb_rdata", rd, 32'h0000_AB22);
        check("sb_ntx", 32'(log_n - mark), 32'd0);

        // fill ways 1..3 of set 0
        cpu_op(1'b0, 2'b10, 32'h1800, '0, rd, cyc);
        check("fill1_rdata", rd, 32'hA000_1800);
        check("fill1_cycles", 32'(cyc), 32'd9);
        cpu_op(1'b0, 2'b10, 32'h2000, '0, rd, cyc);
        check("fill2_rdata", rd, 32'hA000_2000);
        cpu_op(1'b0, 2'b10, 32'h2808, '0, rd, cyc);
        check("fill3_rdata", rd, 32'hA000_2808);
        check("fill3_cycles", 32'(cyc), 32'd9);

        // fifth tag evicts dirty way 0 (rr=0): 4 writes then 4 reads
        mark = log_n;
        cpu_op(1'b0, 2'b10, 32'h3000, '0, rd, cyc);
        check("evict_rdata", rd, 32'hA000_3000);
        check("evict_cycles", 32'(cyc), 32'd17);
        check("evict_ntx", 32'(log_n - mark), 32'd8);
        check_log("evict_wb", mark, 4, 1'b1, 32'h1000);
        check_log("evict_rf", mark + 4, 4, 1'b0, 32'h3000);
        wb_exp[0] = 32'h11; wb_exp[1] = 32'h0000_AB22; wb_exp[2] = 32'h33; wb_exp[3] = 32'h44;
        for (int i = 0; i < 4; i++) check("evict_wdata", log_wdata[mark+i], wb_exp[i]);

        // rr is now 1: next conflict evicts way 1 (0x1800), way 2 still hits
        cpu_op(1'b0, 2'b10, 32'h3800, '0, rd, cyc);
        check("rr1_cycles", 32'(cyc), 32'd9);
        cpu_op(1'b0, 2'b10, 32'h2000, '0, rd, cyc);
        check("rr1_way2_hit", 32'(cyc), 32'd0);
        cpu_op(1'b0, 2'b10, 32'h1800, '0, rd, cyc);
        check("rr1_way1_gone", 32'(cyc), 32'd9);
        // written-back line comes back from memory intact (evicts way 3, clean)
        cpu_op(1'b0, 2'b10, 32'h1004, '0, rd, cyc);
        check("wb_reload_rdata", rd, 32'h0000_AB22);
        check("wb_reload_cycles", 32'(cyc), 32'd9);
        cpu_op(1'b0, 2'b10, 32'h3000, '0, rd, cyc);
        check("way0_hit", 32'(cyc), 32'd0);

        // reset in the middle of a refill (word 2 in flight)
        mark = log_n;
        @(negedge clk);
        cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'b10; cpu_data_addr = 32'h0104;
        cyc = 0;
        while ((log_n - mark) < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rf_word2_reached", 32'(log_n - mark), 32'd3);
        rst = 1'b1; cpu_data_req = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(cache_data_req), 32'd0);
        check("midrst_mem_wr", 32'(cache_data_wr), 32'd0);
        check("midrst_data_ok", 32'(cpu_data_data_ok), 32'd0);
        rst = 1'b0;
        mark = log_n;
        cpu_op(1'b0, 2'b10, 32'h0104, '0, rd, cyc);
        check("postrst_rdata", rd, 32'hA000_0104);
        check("postrst_cycles", 32'(cyc), 32'd9);
        check("postrst_ntx", 32'(log_n - mark), 32'd4);
        check_log("postrst", mark, 4, 1'b0, 32'h0100);
        cpu_op(1'b0, 2'b10, 32'h3000, '0, rd, cyc);
        check("postrst_invalid", 32'(cyc), 32'd9);

        // stalled memory: addr_ok after 3 extra cycles, data_ok after 5
        adly = 3; ddly = 5;
        mark = log_n;
        cpu_op(1'b0, 2'b10, 32'h0204, '0, rd, cyc);
        check("stall_rdata", rd, 32'hA000_0204);
        check("stall_cycles", 32'(cyc), 32'd41);
        check("stall_ntx", 32'(log_n - mark), 32'd4);
        check_log("stall", mark, 4, 1'b0, 32'h0200);

        // store miss under stall, then hits on the allocated line
        cpu_op(1'b1, 2'b10, 32'h0308, 32'hDEAD_BEEF, rd, cyc);
        check("stmiss_cycles", 32'(cyc), 32'd41);
        cpu_op(1'b0, 2'b10, 32'h0308, '0, rd, cyc);
        check("stmiss_rdata", rd, 32'hDEAD_BEEF);
        check("stmiss_hit", 32'(cyc), 32'd0);
        cpu_op(1'b1, 2'b01, 32'h0306, 32'h5566_0000, rd, cyc);
        check("sh_cycles", 32'(cyc), 32'd0);
        cpu_op(1'b0, 2'b10, 32'h0304, '0, rd, cyc);
        check("sh_rdata", rd, 32'h5566_0304);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
